host_boot_ctrl: RTL and testbench

TL-UL register-mapped boot sequencer for the host cluster. It keeps the Ibex core gated, with fetch disabled and the core held in reset, while an external loader fills instruction memory through the main-side port. Once software writes GO, it releases the core with a programmable boot address. It also watches the core's major alerts, halts fetch on a fault, and counts run cycles.

---
 rtl/host_boot_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_host_boot_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_boot_ctrl.sv
// host_boot_ctrl: TL-UL register-mapped boot sequencer that gates, resets and releases the Ibex core.
// Optional run-cycle counter is built when HOST_BOOT_CTRL_CYCLE_CNT_EN is defined.

package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

package ibex_pkg;
  typedef logic [3:0] fetch_enable_t;
  parameter fetch_enable_t IbexMuBiOn  = 4'b0101;
  parameter fetch_enable_t IbexMuBiOff = 4'b1010;
endpackage

module tlul_rsp_intg_gen
  import tlul_pkg::*;
(
  input  tl_d2h_t tl_i,
  output tl_d2h_t tl_o
);
  logic [5:0]  w_meta;
  logic [34:0] w_pad;

  assign w_meta = {tl_i.d_opcode, tl_i.d_size, tl_i.d_error};
  assign w_pad  = {3'b000, tl_i.d_data};

  // Folded parity over the response header and data words
  always_comb begin
    tl_o                  = tl_i;
    tl_o.d_user.rsp_intg  = {^w_meta, w_meta};
    tl_o.d_user.data_intg = w_pad[6:0] ^ w_pad[13:7] ^ w_pad[20:14] ^ w_pad[27:21] ^ w_pad[34:28];
  end
endmodule

module host_boot_ctrl
  import tlul_pkg::*;
  import ibex_pkg::*;
#(
  parameter logic [31:0] BootAddrDefault = 32'h0000_0000,
  parameter int unsigned ResetHoldCycles = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  tl_h2d_t       tl_i,
  output tl_d2h_t       tl_o,
  output fetch_enable_t fetch_enable_o,
  output logic [31:0]   boot_addr_o,
  output logic          core_rst_no,
  input  logic          core_sleep_i,
  input  logic          alert_major_i
);
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StRun  = 2'd2,
    StHalt = 2'd3
  } state_e;

  localparam logic [7:0] HoldLoad = 8'(ResetHoldCycles - 1);

  state_e        r_state, w_state_nxt;
  logic [7:0]    r_hold_cnt, w_hold_cnt_nxt;
  logic          r_fault, w_fault_nxt;
  logic [31:0]   r_boot_addr;
  logic          r_core_rst_n;
  fetch_enable_t r_fetch_en;

  logic          r_d_valid;
  tl_d_op_e      r_d_opcode;
  logic [1:0]    r_d_size;
  logic [7:0]    r_d_source;
  logic [31:0]   r_d_data;
  logic          r_d_error;

  logic          w_a_ready, w_accept, w_is_get, w_is_write, w_mapped, w_cfg_ok, w_err;
  logic          w_wr_ok, w_go, w_halt_req, w_boot_we;
  logic [3:0]    w_offset;
  logic [31:0]   w_rdata, w_cycles;
  tl_d2h_t       w_tl_rsp;
  logic          w_unused_param;

  assign w_unused_param = ^tl_i.a_param;

  assign w_a_ready  = !r_d_valid || tl_i.d_ready;
  assign w_accept   = tl_i.a_valid && w_a_ready;
  assign w_offset   = tl_i.a_address[3:0];
  assign w_mapped   = (tl_i.a_address[31:4] == 28'h0) && (tl_i.a_address[1:0] == 2'b00);
  assign w_is_get   = (tl_i.a_opcode == Get);
  assign w_is_write = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
  assign w_cfg_ok   = (r_state == StIdle) || (r_state == StHalt);

  // BOOT_ADDR is only writable while the core is not being brought up or running
  assign w_err = (!w_is_get && !w_is_write) || (tl_i.a_opcode == PutPartialData) ||
                 (tl_i.a_size != 2'd2) || !w_mapped ||
                 (w_is_write && (tl_i.a_mask != 4'hF)) ||
                 (w_is_write && ((w_offset == 4'h8) || (w_offset == 4'hC))) ||
                 (w_is_write && (w_offset == 4'h4) && !w_cfg_ok);

  assign w_wr_ok    = w_accept && w_is_write && !w_err;
  assign w_halt_req = w_wr_ok && (w_offset == 4'h0) && tl_i.a_data[1];
  assign w_go       = w_wr_ok && (w_offset == 4'h0) && tl_i.a_data[0] && !tl_i.a_data[1];
  assign w_boot_we  = w_wr_ok && (w_offset == 4'h4);

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_fault_nxt    = r_fault;
    case (r_state)
      StIdle, StHalt: begin
        if (w_go) begin
          w_state_nxt    = StHold;
          w_hold_cnt_nxt = HoldLoad;
          w_fault_nxt    = 1'b0;
        end
      end
      StHold: begin
        if (w_halt_req)               w_state_nxt    = StIdle;
        else if (r_hold_cnt == 8'd0)  w_state_nxt    = StRun;
        else                          w_hold_cnt_nxt = r_hold_cnt - 8'd1;
      end
      StRun: begin
        // A fault outranks a simultaneous software halt so it is never lost
        if (alert_major_i) begin
          w_state_nxt = StHalt;
          w_fault_nxt = 1'b1;
        end else if (w_halt_req) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= StIdle;
      r_hold_cnt   <= 8'd0;
      r_fault      <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_fetch_en   <= IbexMuBiOff;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_fault      <= w_fault_nxt;
      r_core_rst_n <= (w_state_nxt == StRun) || (w_state_nxt == StHalt);
      r_fetch_en   <= (w_state_nxt == StRun) ? IbexMuBiOn : IbexMuBiOff;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        r_boot_addr <= BootAddrDefault;
    else if (w_boot_we) r_boot_addr <= {tl_i.a_data[31:2], 2'b00};
  end

`ifdef HOST_BOOT_CTRL_CYCLE_CNT_EN
  logic [31:0] r_cycles;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                  r_cycles <= 32'd0;
    else if (w_go && w_cfg_ok)                    r_cycles <= 32'd0;
    else if (r_state == StRun)                    r_cycles <= r_cycles + 32'd1;
  end

  assign w_cycles = r_cycles;
`else
  assign w_cycles = 32'd0;
`endif

  always_comb begin
    w_rdata = 32'd0;
    case (w_offset)
      4'h4:    w_rdata = r_boot_addr;
      4'h8:    w_rdata = {28'h0, r_fault, core_sleep_i, r_state};
      4'hC:    w_rdata = w_cycles;
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_d_valid  <= 1'b0;
      r_d_opcode <= AccessAck;
      r_d_size   <= 2'd0;
      r_d_source <= 8'd0;
      r_d_data   <= 32'd0;
      r_d_error  <= 1'b0;
    end else if (w_accept) begin
      r_d_valid  <= 1'b1;
      r_d_opcode <= w_is_get ? AccessAckData : AccessAck;
      r_d_size   <= tl_i.a_size;
      r_d_source <= tl_i.a_source;
      r_d_data   <= (w_is_get && !w_err) ? w_rdata : 32'd0;
      r_d_error  <= w_err;
    end else if (tl_i.d_ready) begin
      r_d_valid  <= 1'b0;
    end
  end

  always_comb begin
    w_tl_rsp          = '0;
    w_tl_rsp.d_valid  = r_d_valid;
    w_tl_rsp.d_opcode = r_d_opcode;
    w_tl_rsp.d_size   = r_d_size;
    w_tl_rsp.d_source = r_d_source;
    w_tl_rsp.d_data   = r_d_data;
    w_tl_rsp.d_error  = r_d_error;
    w_tl_rsp.a_ready  = w_a_ready;
  end

  tlul_rsp_intg_gen u_rsp_intg (
    .tl_i (w_tl_rsp),
    .tl_o (tl_o)
  );

  assign fetch_enable_o = r_fetch_en;
  assign boot_addr_o    = r_boot_addr;
  assign core_rst_no    = r_core_rst_n;
endmodule

// File: tb/tb_host_boot_ctrl.sv
// Bench for host_boot_ctrl: directed boot, alert, error and reset steps with randomized values,
// checked against a cycle-time model of the sequencer (optionally with HOST_BOOT_CTRL_CYCLE_CNT_EN).
module tb_host_boot_ctrl;
  import tlul_pkg::*;
  import ibex_pkg::*;

  localparam int unsigned Rh      = 16;
  localparam logic [31:0] BootDef = 32'h2000_0080;
  localparam int StIdle = 0, StHold = 1, StRun = 2, StHalt = 3;
`ifdef HOST_BOOT_CTRL_CYCLE_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic          clk, rstN;
  tl_h2d_t       tlReq;
  tl_d2h_t       tlRsp;
  fetch_enable_t fetchEn;
  logic [31:0]   bootAddr;
  logic          coreRstN, coreSleep, alert;

  int errors = 0;
  int checks = 0;

  int          mState;
  logic        mFault;
  logic [31:0] mBoot;
  logic [31:0] mCycles;
  longint      tRun;

  host_boot_ctrl #(.BootAddrDefault(BootDef), .ResetHoldCycles(Rh)) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .tl_i           (tlReq),
    .tl_o           (tlRsp),
    .fetch_enable_o (fetchEn),
    .boot_addr_o    (bootAddr),
    .core_rst_no    (coreRstN),
    .core_sleep_i   (coreSleep),
    .alert_major_i  (alert)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // CYCLES as the spec defines it: one count per clock spent in RUN (negedges are 10 time units apart)
  function automatic logic [31:0] expCycles(input longint tAcc);
    logic [31:0] v;
    v = (mState == StRun) ? 32'((tAcc - tRun) / 10) : mCycles;
    return CntEn ? v : 32'd0;
  endfunction

  function automatic void freezeCycles(input longint tLastRun);
    mCycles = 32'((tLastRun - tRun) / 10) + 32'd1;
  endfunction

  function automatic logic [31:0] statusExp();
    return {28'h0, mFault, coreSleep, 2'(mState)};
  endfunction

  function automatic logic [31:0] expRead(input logic [31:0] addr, input longint tAcc);
    case (addr)
      32'h4:   return mBoot;
      32'h8:   return statusExp();
      32'hC:   return expCycles(tAcc);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic modelErr(input logic [2:0] op, input logic [31:0] addr,
                                    input logic [3:0] mask, input logic [1:0] size);
    logic wr;
    wr = (op == 3'h0) || (op == 3'h1);
    if (op == 3'h1) return 1'b1;
    if (!wr && op != 3'h4) return 1'b1;
    if (size != 2'd2) return 1'b1;
    if (addr > 32'hC || addr[1:0] != 2'b00) return 1'b1;
    if (wr && mask != 4'hF) return 1'b1;
    if (wr && (addr == 32'h8 || addr == 32'hC)) return 1'b1;
    if (wr && addr == 32'h4 && (mState == StHold || mState == StRun)) return 1'b1;
    return 1'b0;
  endfunction

  // One TL-UL transaction; returns at the negedge of the cycle after acceptance
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] mask, input logic [1:0] size, input logic alertAtAccept,
                               output logic [31:0] rdata, output logic rerr, output longint tAcc);
    logic [7:0] src;
    @(negedge clk);
    tAcc              = $time;
    src               = 8'($urandom);
    tlReq.a_opcode    = tl_a_op_e'(op);
    tlReq.a_address   = addr;
    tlReq.a_data      = data;
    tlReq.a_mask      = mask;
    tlReq.a_size      = size;
    tlReq.a_source    = src;
    tlReq.d_ready     = 1'b1;
    tlReq.a_valid     = 1'b1;
    alert             = alertAtAccept;
    @(posedge clk);
    @(negedge clk);
    tlReq.a_valid = 1'b0;
    alert         = 1'b0;
    checkOutput("d_valid latency", tlRsp.d_valid, 1);
    checkOutput("d_source echo", tlRsp.d_source, src);
    checkOutput("d_size echo", tlRsp.d_size, size);
    checkOutput("d_opcode", tlRsp.d_opcode, (op == 3'h4) ? 32'd1 : 32'd0);
    rdata = tlRsp.d_data;
    rerr  = tlRsp.d_error;
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, output logic err,
                         output longint tAcc);
    logic [31:0] rd;
    applyStimulus(3'h0, addr, data, 4'hF, 2'd2, 1'b0, rd, err, tAcc);
  endtask

  task automatic doRead(input string tag, input logic [31:0] addr);
    logic [31:0] rd;
    logic        err;
    longint      tAcc;
    applyStimulus(3'h4, addr, 32'h0, 4'hF, 2'd2, 1'b0, rd, err, tAcc);
    checkOutput({tag, " err"}, err, 0);
    checkOutput(tag, rd, expRead(addr, tAcc));
  endtask

  // Called at the negedge of the first HOLD cycle; counts cycles until the core leaves reset
  task automatic waitRunCheck(input string tag);
    int lowCnt, badFetch;
    lowCnt   = 0;
    badFetch = 0;
    while (coreRstN !== 1'b1 && lowCnt < 300) begin
      if (fetchEn !== IbexMuBiOff) badFetch++;
      lowCnt++;
      @(negedge clk);
    end
    checkOutput({tag, " hold length"}, lowCnt, Rh);
    checkOutput({tag, " fetch gated in HOLD"}, badFetch, 0);
    checkOutput({tag, " fetch on in RUN"}, fetchEn, IbexMuBiOn);
    tRun   = $time;
    mState = StRun;
  endtask

  task automatic randomSweep(input int n);
    logic [31:0] addrs [7];
    addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h44, 32'h6};
    for (int i = 0; i < n; i++) begin
      logic [2:0]  op;
      logic [31:0] addr, data, rd;
      logic [3:0]  mask;
      logic [1:0]  size;
      logic        err, expErr;
      longint      tAcc;
      case ($urandom_range(0, 2))
        0:       op = 3'h4;
        1:       op = 3'h0;
        default: op = 3'h1;
      endcase
      addr = addrs[$urandom_range(0, 6)];
      data = $urandom;
      if (addr == 32'h0) data[1:0] = 2'b00;
      mask   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      size   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd2;
      expErr = modelErr(op, addr, mask, size);
      applyStimulus(op, addr, data, mask, size, 1'b0, rd, err, tAcc);
      checkOutput("sweep d_error", err, expErr);
      if (!expErr && op == 3'h0 && addr == 32'h4) mBoot = {data[31:2], 2'b00};
      if (!expErr && op == 3'h4) checkOutput("sweep rdata", rd, expRead(addr, tAcc));
    end
  endtask

  task automatic backpressureCheck();
    @(negedge clk);
    tlReq.a_opcode  = Get;
    tlReq.a_address = 32'h4;
    tlReq.a_mask    = 4'hF;
    tlReq.a_size    = 2'd2;
    tlReq.d_ready   = 1'b0;
    tlReq.a_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tlReq.a_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp d_valid held", tlRsp.d_valid, 1);
      checkOutput("bp d_data stable", tlRsp.d_data, mBoot);
      checkOutput("bp a_ready low", tlRsp.a_ready, 0);
      @(negedge clk);
    end
    tlReq.d_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp d_valid drops", tlRsp.d_valid, 0);
    checkOutput("bp a_ready back", tlRsp.a_ready, 1);
  endtask

  initial begin
    logic [31:0] rd, rnd;
    logic        err;
    longint      tAcc, tA;

    tlReq = '0;
    tlReq.d_ready = 1'b1;
    coreSleep = 1'b0;
    alert     = 1'b0;
    rstN      = 1'b0;
    mState = StIdle; mFault = 1'b0; mBoot = BootDef; mCycles = 32'd0; tRun = 0;

    repeat (3) @(negedge clk);
    checkOutput("reset core_rst_no", coreRstN, 0);
    checkOutput("reset fetch", fetchEn, IbexMuBiOff);
    checkOutput("reset boot_addr_o", bootAddr, BootDef);
    checkOutput("reset d_valid", tlRsp.d_valid, 0);
    checkOutput("reset a_ready", tlRsp.a_ready, 1);
    rstN = 1'b1;
    doRead("reset STATUS", 32'h8);
    doRead("reset BOOT_ADDR", 32'h4);
    doRead("reset CYCLES", 32'hC);

    @(negedge clk); alert = 1'b1;
    @(negedge clk); alert = 1'b0;
    doRead("alert ignored in IDLE", 32'h8);

    randomSweep(12);
    doRead("BOOT_ADDR after idle sweep", 32'h4);

    doWrite(32'h4, 32'h0000_1003, err, tAcc);
    checkOutput("BOOT_ADDR write err", err, 0);
    mBoot = 32'h0000_1000;
    doRead("BOOT_ADDR low bits forced", 32'h4);
    checkOutput("boot_addr_o", bootAddr, 32'h0000_1000);
    doWrite(32'h0, 32'h1, err, tAcc);
    checkOutput("GO err", err, 0);
    mState = StHold; mFault = 1'b0;
    waitRunCheck("boot");
    doRead("STATUS in RUN", 32'h8);
    coreSleep = 1'b1;
    doRead("STATUS sleep bit", 32'h8);
    coreSleep = 1'b0;
    repeat (100) @(negedge clk);
    doRead("CYCLES after 100", 32'hC);

    randomSweep(8);

    doWrite(32'h4, $urandom, err, tAcc);
    checkOutput("BOOT_ADDR write in RUN err", err, 1);
    checkOutput("boot_addr_o kept in RUN", bootAddr, mBoot);
    doWrite(32'h0, 32'h1, err, tAcc);
    checkOutput("GO in RUN err", err, 0);
    doRead("GO in RUN ignored", 32'h8);
    doRead("CYCLES not cleared by ignored GO", 32'hC);
    applyStimulus(3'h1, 32'h0, 32'h2, 4'hF, 2'd2, 1'b0, rd, err, tAcc);
    checkOutput("PutPartial err", err, 1);
    applyStimulus(3'h0, 32'h0, 32'h2, 4'h3, 2'd2, 1'b0, rd, err, tAcc);
    checkOutput("partial mask err", err, 1);
    applyStimulus(3'h0, 32'h10, 32'h2, 4'hF, 2'd2, 1'b0, rd, err, tAcc);
    checkOutput("addr 0x10 err", err, 1);
    doRead("STATUS after errored writes", 32'h8);

    repeat ($urandom_range(3, 40)) @(negedge clk);
    alert = 1'b1;
    tA    = $time;
    @(negedge clk);
    alert = 1'b0;
    freezeCycles(tA);
    mState = StHalt; mFault = 1'b1;
    checkOutput("alert fetch off", fetchEn, IbexMuBiOff);
    checkOutput("alert core_rst_no", coreRstN, 1);
    doRead("STATUS HALT fault", 32'h8);
    doRead("CYCLES frozen in HALT", 32'hC);

    rnd = $urandom;
    doWrite(32'h4, rnd, err, tAcc);
    checkOutput("BOOT_ADDR write in HALT err", err, 0);
    mBoot = {rnd[31:2], 2'b00};
    checkOutput("boot_addr_o in HALT", bootAddr, mBoot);
    doWrite(32'h0, 32'h1, err, tAcc);
    mState = StHold; mFault = 1'b0;
    waitRunCheck("restart");
    doRead("STATUS fault cleared", 32'h8);
    doRead("CYCLES restarted", 32'hC);

    repeat ($urandom_range(1, 20)) @(negedge clk);
    doWrite(32'h0, 32'h3, err, tAcc);
    checkOutput("CTRL=3 err", err, 0);
    freezeCycles(tAcc);
    mState = StIdle;
    checkOutput("CTRL=3 core_rst_no", coreRstN, 0);
    checkOutput("CTRL=3 fetch", fetchEn, IbexMuBiOff);
    doRead("STATUS after CTRL=3", 32'h8);
    doRead("CYCLES after halt request", 32'hC);

    doWrite(32'h0, 32'h1, err, tAcc);
    mState = StHold; mFault = 1'b0;
    waitRunCheck("third boot");
    repeat (5) @(negedge clk);
    applyStimulus(3'h0, 32'h0, 32'h2, 4'hF, 2'd2, 1'b1, rd, err, tAcc);
    checkOutput("alert+HALT_REQ err", err, 0);
    freezeCycles(tAcc);
    mState = StHalt; mFault = 1'b1;
    checkOutput("alert wins core_rst_no", coreRstN, 1);
    checkOutput("alert wins fetch", fetchEn, IbexMuBiOff);
    doRead("alert wins STATUS", 32'h8);

    backpressureCheck();

    doWrite(32'h0, 32'h1, err, tAcc);
    mState = StHold; mFault = 1'b0;
    doRead("STATUS in HOLD", 32'h8);
    repeat (3) @(negedge clk);
    rstN = 1'b0;
    #1;
    mState = StIdle; mFault = 1'b0; mBoot = BootDef; mCycles = 32'd0;
    checkOutput("mid-HOLD reset core_rst_no", coreRstN, 0);
    checkOutput("mid-HOLD reset fetch", fetchEn, IbexMuBiOff);
    checkOutput("mid-HOLD reset boot_addr_o", bootAddr, BootDef);
    checkOutput("mid-HOLD reset d_valid", tlRsp.d_valid, 0);
    checkOutput("mid-HOLD reset a_ready", tlRsp.a_ready, 1);
    @(negedge clk);
    rstN = 1'b1;
    doRead("post-reset STATUS", 32'h8);
    doRead("post-reset BOOT_ADDR", 32'h4);
    doRead("post-reset CYCLES", 32'hC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
